key_menu_ctrl: RTL and testbench

- Menu/config sequencer driven by the short/long press pulses of two debounced key instances.
- Key 0 (SEL) and key 1 (ADJ) let the user browse NFIELD config fields, edit one value, and commit or cancel the edit.
- A commit is written to the MLP/PLL configuration register bank over a valid/ready write port.
- Keeps a shadow copy of every field and drives a display value.

---
 rtl/key_menu_pkg.sv | 6 +
 rtl/key_menu_ctrl_timeout.sv | 17 +
 rtl/key_menu_ctrl.sv | 93 +++++++++
 tb/tb_key_menu_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_menu_pkg.sv
// key_menu_pkg: state encoding and key bit indices shared by the key menu sequencer.
package key_menu_pkg;
   typedef enum logic [1:0] {BROWSE = 2'd0, EDIT = 2'd1, COMMIT = 2'd2} state_t;
   localparam int KEY_SEL = 0;
   localparam int KEY_ADJ = 1;
endpackage

// File: rtl/key_menu_ctrl_timeout.sv
// menu_timeout: 32-bit inactivity counter with clear, enable and terminal-count pulse.
module menu_timeout #(
   parameter int TIMEOUT_CNT = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [31:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 32'd1;
   assign tc = en && (cnt == 32'(TIMEOUT_CNT - 1));
endmodule

// File: rtl/key_menu_ctrl.sv
// key_menu_ctrl: two-key menu sequencer that browses, edits and commits config fields
// to a valid/ready config bank while keeping a shadow copy for display.
module key_menu_ctrl
   import key_menu_pkg::*;
#(
   parameter int CLK_FREQ   = 27_000_000,
   parameter int NFIELD     = 4,
   parameter int DW         = 8,
   parameter int MAX_VAL    = 255,
   parameter int TIMEOUT_MS = 5000,
   localparam int AW        = $clog2(NFIELD)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    key_short,
   input  logic [1:0]    key_long,
   output logic          cfg_valid,
   input  logic          cfg_ready,
   output logic [AW-1:0] cfg_addr,
   output logic [DW-1:0] cfg_data,
   output logic [AW-1:0] sel,
   output logic          edit_mode,
   output logic [DW-1:0] disp_val,
   output logic          timeout_evt
);
   localparam int TIMEOUT_CNT = (CLK_FREQ / 1000) * TIMEOUT_MS;
   localparam logic [DW-1:0] MAXV = DW'(MAX_VAL);
   localparam logic [AW-1:0] LAST = AW'(NFIELD - 1);
   state_t state;
   logic [DW-1:0] edit_val;
   logic [DW-1:0] shadow [NFIELD];
   logic ev_ls, ev_la, ev_ss, ev_sa, ev_any, to_clr, to_en, to_tc;
   // fixed-priority pick: long SEL > long ADJ > short SEL > short ADJ, losers dropped
   assign ev_ls  = key_long[KEY_SEL];
   assign ev_la  = key_long[KEY_ADJ] && !key_long[KEY_SEL];
   assign ev_ss  = key_short[KEY_SEL] && !(|key_long);
   assign ev_sa  = key_short[KEY_ADJ] && !(|key_long) && !key_short[KEY_SEL];
   assign ev_any = |{key_long, key_short};
   assign to_clr = (state == BROWSE && ev_ls) || (state == EDIT && ev_any);
   assign to_en  = state == EDIT;
   menu_timeout #(.TIMEOUT_CNT(TIMEOUT_CNT)) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (to_clr),
      .en    (to_en),
      .tc    (to_tc)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BROWSE;
         sel         <= '0;
         edit_val    <= '0;
         cfg_valid   <= 1'b0;
         cfg_addr    <= '0;
         cfg_data    <= '0;
         timeout_evt <= 1'b0;
         for (int i = 0; i < NFIELD; i++) shadow[i] <= '0;
      end else begin
         timeout_evt <= 1'b0;
         case (state)
            BROWSE:
               if (ev_ls) begin
                  edit_val <= shadow[sel];
                  state    <= EDIT;
               end else if (ev_ss) sel <= (sel == LAST) ? '0 : sel + 1'b1;
            EDIT:
               if (ev_ls) begin
                  cfg_addr  <= sel;
                  cfg_data  <= edit_val;
                  cfg_valid <= 1'b1;
                  state     <= COMMIT;
               end else if (ev_la) state <= BROWSE;
               else if (ev_ss) edit_val <= (edit_val == '0) ? MAXV : edit_val - 1'b1;
               else if (ev_sa) edit_val <= (edit_val == MAXV) ? '0 : edit_val + 1'b1;
               else if (to_tc) begin
                  state       <= BROWSE;
                  timeout_evt <= 1'b1;
               end
            COMMIT:
               if (cfg_valid && cfg_ready) begin
                  shadow[cfg_addr] <= cfg_data;
                  cfg_valid        <= 1'b0;
                  state            <= BROWSE;
               end
            default: state <= BROWSE;
         endcase
      end
   end
   always_comb begin
      disp_val  = (state == EDIT) ? edit_val : (state == COMMIT) ? cfg_data : shadow[sel];
      edit_mode = state != BROWSE;
   end
endmodule

// File: tb/tb_key_menu_ctrl.sv
// tb_key_menu_ctrl: vector table, corner-case sequences and random traffic checked
// against a behavioural menu model.
module tb_key_menu_ctrl;
   localparam int N  = 4;
   localparam int MX = 9;
   localparam int TO = 50;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] key_short, key_long;
   logic       cfg_ready, cfg_valid, edit_mode, timeout_evt;
   logic [1:0] cfg_addr, sel;
   logic [7:0] cfg_data, disp_val;
   int n_cmp = 0;
   int n_err = 0;
   int m_mode, m_sel, m_edit, m_valid, m_addr, m_data, m_tevt, m_idle;
   int m_sh [N];
   typedef struct {
      logic [1:0] ks;
      logic [1:0] kl;
      logic       rdy;
      int sel, em, disp, valid, addr, data;
   } vec_t;
   vec_t vt [25];

   key_menu_ctrl #(
      .CLK_FREQ(1000), .NFIELD(N), .DW(8), .MAX_VAL(MX), .TIMEOUT_MS(TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_short   (key_short),
      .key_long    (key_long),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .sel         (sel),
      .edit_mode   (edit_mode),
      .disp_val    (disp_val),
      .timeout_evt (timeout_evt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_sel = 0; m_edit = 0; m_valid = 0;
      m_addr = 0; m_data = 0; m_tevt = 0; m_idle = 0;
      for (int i = 0; i < N; i++) m_sh[i] = 0;
   endtask

   // menu rules expressed with modulo arithmetic and an idle-cycle count
   task automatic model_step(input logic [1:0] ks, input logic [1:0] kl, input logic rdy);
      int ev;
      ev = kl[0] ? 0 : kl[1] ? 1 : ks[0] ? 2 : ks[1] ? 3 : -1;
      m_tevt = 0;
      if (m_mode == 0) begin
         if (ev == 0) begin
            m_edit = m_sh[m_sel]; m_mode = 1; m_idle = 0;
         end else if (ev == 2) m_sel = (m_sel + 1) % N;
      end else if (m_mode == 1) begin
         if (ev < 0) begin
            m_idle++;
            if (m_idle == TO) begin m_mode = 0; m_tevt = 1; end
         end else begin
            m_idle = 0;
            if (ev == 0) begin
               m_addr = m_sel; m_data = m_edit; m_valid = 1; m_mode = 2;
            end else if (ev == 1) m_mode = 0;
            else if (ev == 2) m_edit = (m_edit + MX) % (MX + 1);
            else m_edit = (m_edit + 1) % (MX + 1);
         end
      end else if (rdy) begin
         m_sh[m_addr] = m_data; m_valid = 0; m_mode = 0;
      end
   endtask

   task automatic check_all(input string tag);
      int ed;
      ed = (m_mode == 0) ? m_sh[m_sel] : (m_mode == 1) ? m_edit : m_data;
      chk({tag, "_sel"}, sel, m_sel);
      chk({tag, "_edit_mode"}, edit_mode, int'(m_mode != 0));
      chk({tag, "_disp_val"}, disp_val, ed);
      chk({tag, "_cfg_valid"}, cfg_valid, m_valid);
      chk({tag, "_cfg_addr"}, cfg_addr, m_addr);
      chk({tag, "_cfg_data"}, cfg_data, m_data);
      chk({tag, "_timeout_evt"}, timeout_evt, m_tevt);
   endtask

   task automatic cyc(input logic [1:0] ks, input logic [1:0] kl, input logic rdy);
      key_short = ks; key_long = kl; cfg_ready = rdy;
      model_step(ks, kl, rdy);
      @(posedge clk);
      #1;
      key_short = 2'b00; key_long = 2'b00;
   endtask

   task automatic wait_timeout(input string nm, input int exp);
      int n = 0;
      bit seen = 0;
      for (int c = 1; c <= 4 * TO && !seen; c++) begin
         cyc(2'b00, 2'b00, 1'b0);
         check_all(nm);
         if (timeout_evt) begin seen = 1; n = c; end
      end
      chk({nm, "_latency"}, n, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vt = '{
         '{2'b01, 2'b00, 1'b0, 1, 0, 0, 0, 0, 0},
         '{2'b01, 2'b00, 1'b0, 2, 0, 0, 0, 0, 0},
         '{2'b01, 2'b00, 1'b0, 3, 0, 0, 0, 0, 0},
         '{2'b01, 2'b00, 1'b0, 0, 0, 0, 0, 0, 0},
         '{2'b01, 2'b00, 1'b0, 1, 0, 0, 0, 0, 0},
         '{2'b01, 2'b00, 1'b0, 2, 0, 0, 0, 0, 0},
         '{2'b00, 2'b01, 1'b0, 2, 1, 0, 0, 0, 0},
         '{2'b10, 2'b00, 1'b0, 2, 1, 1, 0, 0, 0},
         '{2'b10, 2'b00, 1'b0, 2, 1, 2, 0, 0, 0},
         '{2'b10, 2'b00, 1'b0, 2, 1, 3, 0, 0, 0},
         '{2'b00, 2'b01, 1'b1, 2, 1, 3, 1, 2, 3},
         '{2'b00, 2'b00, 1'b1, 2, 0, 3, 0, 2, 3},
         '{2'b01, 2'b00, 1'b0, 3, 0, 0, 0, 2, 3},
         '{2'b00, 2'b01, 1'b0, 3, 1, 0, 0, 2, 3},
         '{2'b01, 2'b00, 1'b0, 3, 1, 9, 0, 2, 3},
         '{2'b10, 2'b00, 1'b0, 3, 1, 0, 0, 2, 3},
         '{2'b00, 2'b10, 1'b0, 3, 0, 0, 0, 2, 3},
         '{2'b00, 2'b01, 1'b0, 3, 1, 0, 0, 2, 3},
         '{2'b10, 2'b10, 1'b0, 3, 0, 0, 0, 2, 3},
         '{2'b01, 2'b01, 1'b0, 3, 1, 0, 0, 2, 3},
         '{2'b00, 2'b10, 1'b0, 3, 0, 0, 0, 2, 3},
         '{2'b01, 2'b10, 1'b0, 3, 0, 0, 0, 2, 3},
         '{2'b01, 2'b00, 1'b0, 0, 0, 0, 0, 2, 3},
         '{2'b01, 2'b00, 1'b0, 1, 0, 0, 0, 2, 3},
         '{2'b01, 2'b00, 1'b0, 2, 0, 3, 0, 2, 3}
      };
      rst_n = 1'b0; key_short = 2'b00; key_long = 2'b00; cfg_ready = 1'b0;
      model_reset();
      #3;
      check_all("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // browse wrap, edit/commit with ready high, wrap edges, priority cases
      for (int i = 0; i < $size(vt); i++) begin
         cyc(vt[i].ks, vt[i].kl, vt[i].rdy);
         chk($sformatf("vec%0d_sel", i), sel, vt[i].sel);
         chk($sformatf("vec%0d_edit_mode", i), edit_mode, vt[i].em);
         chk($sformatf("vec%0d_disp_val", i), disp_val, vt[i].disp);
         chk($sformatf("vec%0d_cfg_valid", i), cfg_valid, vt[i].valid);
         chk($sformatf("vec%0d_cfg_addr", i), cfg_addr, vt[i].addr);
         chk($sformatf("vec%0d_cfg_data", i), cfg_data, vt[i].data);
      end

      // backpressure: field 2 holds 3, commit 4 while ready stays low with key noise
      cyc(2'b00, 2'b01, 1'b0);
      cyc(2'b10, 2'b00, 1'b0);
      cyc(2'b00, 2'b01, 1'b0);
      check_all("bp_enter");
      for (int i = 0; i < 10; i++) begin
         cyc(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
         chk("bp_valid_held", cfg_valid, 1);
         chk("bp_addr_held", cfg_addr, 2);
         chk("bp_data_held", cfg_data, 4);
         check_all("bp_wait");
      end
      cyc(2'b00, 2'b00, 1'b1);
      chk("bp_valid_fall", cfg_valid, 0);
      chk("bp_disp_after", disp_val, 4);
      check_all("bp_done");

      // timeout after one adjust, then a key landing on the terminal cycle
      cyc(2'b00, 2'b01, 1'b0);
      cyc(2'b10, 2'b00, 1'b0);
      wait_timeout("to_first", TO);
      chk("to_edit_mode", edit_mode, 0);
      chk("to_shadow_kept", disp_val, 4);
      cyc(2'b00, 2'b00, 1'b0);
      chk("to_pulse_width", timeout_evt, 0);
      cyc(2'b00, 2'b01, 1'b0);
      cyc(2'b10, 2'b00, 1'b0);
      for (int i = 0; i < TO - 1; i++) begin
         cyc(2'b00, 2'b00, 1'b0);
         check_all("to_idle");
      end
      cyc(2'b10, 2'b00, 1'b0);
      chk("to_key_wins", timeout_evt, 0);
      check_all("to_key");
      wait_timeout("to_delayed", TO);

      // reset while a write is pending
      cyc(2'b00, 2'b01, 1'b0);
      cyc(2'b10, 2'b00, 1'b0);
      cyc(2'b00, 2'b01, 1'b0);
      chk("rst_pre_valid", cfg_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_valid_async", cfg_valid, 0);
      chk("rst_edit_mode", edit_mode, 0);
      model_reset();
      check_all("rst_mid");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rst_shadow%0d", i), disp_val, 0);
         cyc(2'b01, 2'b00, 1'b0);
         check_all("rst_walk");
      end

      // random traffic alternating busy and quiet stretches
      for (int i = 0; i < 2400; i++) begin
         int p;
         logic [1:0] ks, kl;
         p = ((i / 150) % 2 == 1) ? 0 : 6;
         ks = {1'($urandom_range(0, 99) < p), 1'($urandom_range(0, 99) < p)};
         kl = {1'($urandom_range(0, 99) < p), 1'($urandom_range(0, 99) < p)};
         cyc(ks, kl, 1'($urandom_range(0, 3) == 0));
         check_all("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
